// File: rtl/e_mdu_if.sv
// Handshake bundle between the E stage and the multiply/divide unit.
// The master side is the pipeline/CP0 logic; the slave side is e_mdu.
interface e_mdu_if;
   logic        req;
   logic [3:0]  E_MDU_op;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic        E_MDU_start;
   logic        E_MDU_busy;
   logic [31:0] E_MDU_out;

   modport master (
      output req, E_MDU_op, E_A, E_B,
      input  E_MDU_start, E_MDU_busy, E_MDU_out
   );

   modport slave (
      input  req, E_MDU_op, E_A, E_B,
      output E_MDU_start, E_MDU_busy, E_MDU_out
   );
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit with HI/LO and a fixed-latency busy model.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (9-12).
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic    clk,
   input logic    reset,
   e_mdu_if.slave mdu
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          busy;
   logic [31:0]   hi;
   logic [31:0]   lo;
   logic [31:0]   hi_nxt;
   logic [31:0]   lo_nxt;

   logic               is_mult;
   logic               is_div;
   logic               start;
   logic signed [63:0] sa;
   logic signed [63:0] sb;
   logic        [63:0] ua;
   logic        [63:0] ub;
   logic        [63:0] res;
   logic        [31:0] out;

   // The full result is formed at the start edge; the busy window only models latency.
   // Divide by zero keeps the current {HI,LO} so the commit is a no-op.
   always_comb begin
      sa      = {{32{mdu.E_A[31]}}, mdu.E_A};
      sb      = {{32{mdu.E_B[31]}}, mdu.E_B};
      ua      = {32'd0, mdu.E_A};
      ub      = {32'd0, mdu.E_B};
      is_mult = 1'b0;
      is_div  = 1'b0;
      res     = {hi, lo};
      case (mdu.E_MDU_op)
         4'd1: begin
            is_mult = 1'b1;
            res     = 64'(sa * sb);
         end
         4'd2: begin
            is_mult = 1'b1;
            res     = ua * ub;
         end
         4'd3: begin
            is_div = 1'b1;
            if (mdu.E_B != 32'd0)
               res = {32'(sa % sb), 32'(sa / sb)};
         end
         4'd4: begin
            is_div = 1'b1;
            if (mdu.E_B != 32'd0)
               res = {mdu.E_A % mdu.E_B, mdu.E_A / mdu.E_B};
         end
`ifdef MDU_MADD_EN
         4'd9: begin
            is_mult = 1'b1;
            res     = {hi, lo} + 64'(sa * sb);
         end
         4'd10: begin
            is_mult = 1'b1;
            res     = {hi, lo} + (ua * ub);
         end
         4'd11: begin
            is_mult = 1'b1;
            res     = {hi, lo} - 64'(sa * sb);
         end
         4'd12: begin
            is_mult = 1'b1;
            res     = {hi, lo} - (ua * ub);
         end
`endif
         default: ;
      endcase
      start = (is_mult | is_div) & ~mdu.req & ~busy;
   end

   always_comb begin
      out = 32'd0;
      if (mdu.E_MDU_op == 4'd5)
         out = hi;
      else if (mdu.E_MDU_op == 4'd6)
         out = lo;
   end

   // An op already in BUSY has retired past E, so req never cancels it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         cnt    <= '0;
         hi     <= 32'd0;
         lo     <= 32'd0;
         hi_nxt <= 32'd0;
         lo_nxt <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  hi_nxt <= res[63:32];
                  lo_nxt <= res[31:0];
                  cnt    <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  busy   <= 1'b1;
                  state  <= BUSY;
               end else if (!mdu.req && mdu.E_MDU_op == 4'd7) begin
                  hi <= mdu.E_A;
               end else if (!mdu.req && mdu.E_MDU_op == 4'd8) begin
                  lo <= mdu.E_A;
               end
            end
            BUSY: begin
               if (cnt == CW'(1)) begin
                  hi    <= hi_nxt;
                  lo    <= lo_nxt;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign mdu.E_MDU_start = start;
   assign mdu.E_MDU_busy  = busy;
   assign mdu.E_MDU_out   = out;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed vectors plus randomized ops against
// a plain-arithmetic HI/LO model; honours MDU_MADD_EN like the design.
module tb_e_mdu;

   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;

   logic clk = 1'b0;
   logic reset;

   e_mdu_if mdu();

   e_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (mdu)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req_v, output logic start_seen);
      @(negedge clk);
      mdu.E_MDU_op = op;
      mdu.E_A      = a;
      mdu.E_B      = b;
      mdu.req      = req_v;
      #1 start_seen = mdu.E_MDU_start;
      @(posedge clk);
      #1;
      mdu.E_MDU_op = 4'd0;
      mdu.req      = 1'b0;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (mdu.E_MDU_busy === 1'b1 && cycles < 200) begin
         cycles++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic read_hilo(output logic [31:0] hi_r, output logic [31:0] lo_r);
      @(negedge clk);
      mdu.E_MDU_op = 4'd5;
      #1 hi_r = mdu.E_MDU_out;
      mdu.E_MDU_op = 4'd6;
      #1 lo_r = mdu.E_MDU_out;
      mdu.E_MDU_op = 4'd0;
   endtask

   // Architectural effect of one op on {HI,LO}, plus the busy time it should take.
   task automatic model_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int exp_busy);
      longint      sa, sb, q, r;
      logic [63:0] pu, acc;
      sa       = longint'($signed(a));
      sb       = longint'($signed(b));
      pu       = {32'd0, a} * {32'd0, b};
      acc      = {hi_m, lo_m};
      exp_busy = 0;
      case (op)
         4'd1: begin {hi_m, lo_m} = sa * sb; exp_busy = MULT_CYCLES; end
         4'd2: begin {hi_m, lo_m} = pu;      exp_busy = MULT_CYCLES; end
         4'd3: begin
            exp_busy = DIV_CYCLES;
            if (b != 32'd0) begin
               q = sa / sb;
               r = sa % sb;
               lo_m = q[31:0];
               hi_m = r[31:0];
            end
         end
         4'd4: begin
            exp_busy = DIV_CYCLES;
            if (b != 32'd0) begin
               lo_m = a / b;
               hi_m = a % b;
            end
         end
         4'd7: hi_m = a;
         4'd8: lo_m = a;
`ifdef MDU_MADD_EN
         4'd9:  begin {hi_m, lo_m} = acc + sa * sb; exp_busy = MULT_CYCLES; end
         4'd10: begin {hi_m, lo_m} = acc + pu;      exp_busy = MULT_CYCLES; end
         4'd11: begin {hi_m, lo_m} = acc - sa * sb; exp_busy = MULT_CYCLES; end
         4'd12: begin {hi_m, lo_m} = acc - pu;      exp_busy = MULT_CYCLES; end
`endif
         default: ;
      endcase
   endtask

   task automatic test_reset;
      logic [31:0] h, l;
      reset        = 1'b1;
      mdu.req      = 1'b0;
      mdu.E_MDU_op = 4'd0;
      mdu.E_A      = 32'd0;
      mdu.E_B      = 32'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      checks++;
      if (mdu.E_MDU_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", mdu.E_MDU_busy);
      else passes++;
      checks++;
      if (mdu.E_MDU_out !== 32'd0) $display("[TB] FAIL reset_out: got %h expected 0", mdu.E_MDU_out);
      else passes++;
      read_hilo(h, l);
      checks++;
      if ({h, l} !== 64'd0) $display("[TB] FAIL reset_hilo: got %h expected 0", {h, l});
      else passes++;
      hi_m = 32'd0;
      lo_m = 32'd0;
   endtask

   task automatic test_spec_vectors;
      logic [31:0] h, l;
      logic        st;
      int          cyc;
      logic [3:0]  ops [5]   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3};
      logic [31:0] as  [5]   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000};
      logic [31:0] bs  [5]   = '{32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
      int          cy  [5]   = '{MULT_CYCLES, MULT_CYCLES, DIV_CYCLES, DIV_CYCLES, DIV_CYCLES};
      logic [63:0] ex  [5]   = '{64'hFFFFFFFF_FFFFFFFE, 64'h00000001_FFFFFFFE,
                                 64'hFFFFFFFF_FFFFFFFD, 64'hFFFFFFFF_FFFFFFFD,
                                 64'h00000000_80000000};
      for (int i = 0; i < 5; i++) begin
         launch(ops[i], as[i], bs[i], 1'b0, st);
         wait_idle(cyc);
         checks++;
         if (cyc != cy[i]) $display("[TB] FAIL vec%0d_busy: got %0d expected %0d", i, cyc, cy[i]);
         else passes++;
         read_hilo(h, l);
         checks++;
         if ({h, l} !== ex[i]) $display("[TB] FAIL vec%0d_hilo: got %h expected %h", i, {h, l}, ex[i]);
         else passes++;
      end
      {hi_m, lo_m} = ex[4];
   endtask

   task automatic test_req;
      logic [31:0] h, l;
      logic        st;
      int          cyc;
      launch(4'd7, 32'h00001234, 32'd0, 1'b1, st);
      read_hilo(h, l);
      checks++;
      if (h !== hi_m) $display("[TB] FAIL req_mthi: got %h expected %h", h, hi_m);
      else passes++;
      launch(4'd1, 32'd3, 32'd7, 1'b1, st);
      checks++;
      if (st !== 1'b0) $display("[TB] FAIL req_start: got %b expected 0", st);
      else passes++;
      checks++;
      if (mdu.E_MDU_busy !== 1'b0) $display("[TB] FAIL req_busy: got %b expected 0", mdu.E_MDU_busy);
      else passes++;
      launch(4'd1, 32'd3, 32'd7, 1'b0, st);
      @(negedge clk) mdu.req = 1'b1;
      @(negedge clk);
      @(negedge clk) mdu.req = 1'b0;
      wait_idle(cyc);
      read_hilo(h, l);
      checks++;
      if ({h, l} !== 64'd21) $display("[TB] FAIL req_in_busy_commit: got %h expected %h", {h, l}, 64'd21);
      else passes++;
      {hi_m, lo_m} = 64'd21;
   endtask

   task automatic test_busy_ignore;
      logic [31:0] h, l;
      logic        st;
      int          cyc;
      launch(4'd1, 32'd6, 32'd5, 1'b0, st);
      @(negedge clk);
      mdu.E_MDU_op = 4'd7;
      mdu.E_A      = 32'h0000DEAD;
      #1;
      checks++;
      if (mdu.E_MDU_start !== 1'b0) $display("[TB] FAIL busy_start: got %b expected 0", mdu.E_MDU_start);
      else passes++;
      @(posedge clk);
      #1;
      mdu.E_MDU_op = 4'd1;
      mdu.E_A      = 32'd99;
      mdu.E_B      = 32'd99;
      @(posedge clk);
      #1 mdu.E_MDU_op = 4'd0;
      wait_idle(cyc);
      checks++;
      if (cyc != MULT_CYCLES - 2) $display("[TB] FAIL busy_len: got %0d expected %0d", cyc, MULT_CYCLES - 2);
      else passes++;
      read_hilo(h, l);
      checks++;
      if ({h, l} !== 64'd30) $display("[TB] FAIL busy_no_corrupt: got %h expected %h", {h, l}, 64'd30);
      else passes++;
      {hi_m, lo_m} = 64'd30;
   endtask

   task automatic test_madd;
      logic [31:0] h, l;
      logic        st;
      int          cyc;
      launch(4'd7, 32'd0, 32'd0, 1'b0, st);
      launch(4'd8, 32'd5, 32'd0, 1'b0, st);
`ifdef MDU_MADD_EN
      launch(4'd9, 32'd3, 32'd4, 1'b0, st);
      wait_idle(cyc);
      checks++;
      if (cyc != MULT_CYCLES) $display("[TB] FAIL madd_busy: got %0d expected %0d", cyc, MULT_CYCLES);
      else passes++;
      read_hilo(h, l);
      checks++;
      if ({h, l} !== 64'd17) $display("[TB] FAIL madd_result: got %h expected %h", {h, l}, 64'd17);
      else passes++;
      launch(4'd12, 32'd1, 32'd20, 1'b0, st);
      wait_idle(cyc);
      read_hilo(h, l);
      checks++;
      if ({h, l} !== 64'hFFFFFFFF_FFFFFFFD)
         $display("[TB] FAIL msubu_result: got %h expected %h", {h, l}, 64'hFFFFFFFF_FFFFFFFD);
      else passes++;
      {hi_m, lo_m} = 64'hFFFFFFFF_FFFFFFFD;
`else
      launch(4'd9, 32'd3, 32'd4, 1'b0, st);
      checks++;
      if (st !== 1'b0) $display("[TB] FAIL madd_off_start: got %b expected 0", st);
      else passes++;
      wait_idle(cyc);
      checks++;
      if (cyc != 0) $display("[TB] FAIL madd_off_busy: got %0d expected 0", cyc);
      else passes++;
      read_hilo(h, l);
      checks++;
      if ({h, l} !== 64'd5) $display("[TB] FAIL madd_off_hilo: got %h expected %h", {h, l}, 64'd5);
      else passes++;
      {hi_m, lo_m} = 64'd5;
`endif
   endtask

   task automatic test_mid_reset;
      logic [31:0] h, l;
      logic        st;
      launch(4'd7, 32'h0000AAAA, 32'd0, 1'b0, st);
      launch(4'd3, 32'd100, 32'd3, 1'b0, st);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      checks++;
      if (mdu.E_MDU_busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", mdu.E_MDU_busy);
      else passes++;
      read_hilo(h, l);
      checks++;
      if ({h, l} !== 64'd0) $display("[TB] FAIL midreset_hilo: got %h expected 0", {h, l});
      else passes++;
      repeat (DIV_CYCLES + 2) @(posedge clk);
      read_hilo(h, l);
      checks++;
      if ({h, l} !== 64'd0) $display("[TB] FAIL midreset_no_commit: got %h expected 0", {h, l});
      else passes++;
      hi_m = 32'd0;
      lo_m = 32'd0;
   endtask

   task automatic test_random;
      logic [3:0]  op_pool [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8,
                                    4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd15};
      logic [31:0] corner  [4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1};
      logic [3:0]  op;
      logic [31:0] a, b, h, l;
      logic        st;
      int          cyc, exp_busy;
      for (int i = 0; i < 40; i++) begin
         op = op_pool[$urandom_range(0, 12)];
         a  = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         b  = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if ($urandom_range(0, 3) == 0) b = b & 32'h0000000F;
         launch(op, a, b, 1'b0, st);
         wait_idle(cyc);
         model_step(op, a, b, exp_busy);
         checks++;
         if (st !== (exp_busy != 0)) $display("[TB] FAIL rnd%0d_start op=%0d: got %b expected %b", i, op, st, exp_busy != 0);
         else passes++;
         checks++;
         if (cyc != exp_busy) $display("[TB] FAIL rnd%0d_busy op=%0d: got %0d expected %0d", i, op, cyc, exp_busy);
         else passes++;
         read_hilo(h, l);
         checks++;
         if ({h, l} !== {hi_m, lo_m})
            $display("[TB] FAIL rnd%0d_hilo op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, {h, l}, {hi_m, lo_m});
         else passes++;
      end
   endtask

   initial begin
      test_reset;
      test_spec_vectors;
      test_req;
      test_busy_ignore;
      test_madd;
      test_mid_reset;
      test_random;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
